// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the coarse TDC counter.
// Optional INPUT_SYNC_EN build adds input synchronizers in tdc_edge_detect.
`default_nettype none
`timescale 1ns/1ps

package tdc_pkg;

  localparam int TDC_COARSE_WIDTH = 16;

  // Result word reported when no stop arrives before the counter saturates.
  localparam logic [TDC_COARSE_WIDTH-1:0] TDC_OVF_SENTINEL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } tdc_state_e;

endpackage

`default_nettype wire

// File: rtl/tdc_coarse_counter_if.sv
// tdc_coarse_counter_if: control, event and result-handshake bundle.
// master = measuring block, slave = controller/readout side.
`default_nettype none
`timescale 1ns/1ps

interface tdc_coarse_counter_if #(
  parameter int WIDTH = tdc_pkg::TDC_COARSE_WIDTH
);

  logic             enable;
  logic             start;
  logic             stop;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             valid;
  logic             busy;

  modport master (
    input  enable, start, stop, ready,
    output result, overflow, valid, busy
  );

  modport slave (
    output enable, start, stop, ready,
    input  result, overflow, valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/tdc_edge_detect.sv
// tdc_edge_detect: one-flop rising-edge detector; with INPUT_SYNC_EN the
// input first passes a SYNC_STAGES-deep synchronizer chain.
`default_nettype none
`timescale 1ns/1ps

module tdc_edge_detect
`ifdef INPUT_SYNC_EN
  #(parameter int SYNC_STAGES = 2)
`endif
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic din,
  output logic      rise
);

  logic w_sample;
  logic r_prev;

`ifdef INPUT_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1];
`else
  assign w_sample = din;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sample;
    end
  end

  assign rise = w_sample & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/tdc_coarse_counter.sv
// tdc_coarse_counter: counts clk cycles from a start rising edge to a stop
// rising edge and hands the result over valid/ready. Macro: INPUT_SYNC_EN.
`default_nettype none
`timescale 1ns/1ps

module tdc_coarse_counter
  import tdc_pkg::*;
#(
  parameter int WIDTH = TDC_COARSE_WIDTH
`ifdef INPUT_SYNC_EN
  , parameter int SYNC_STAGES = 2
`endif
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  tdc_coarse_counter_if.master   bus
);

  localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_CNT_LIMIT = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] c_OVF_VALUE = {WIDTH{1'b1}};

  logic             w_start_re;
  logic             w_stop_re;
  tdc_state_e       r_state;
  tdc_state_e       w_next_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_valid;
  logic             r_busy;
  logic             w_cnt_clear;
  logic             w_cnt_inc;
  logic             w_load;
  logic             w_load_ovf;

`ifdef INPUT_SYNC_EN
  tdc_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start_edge (
    .clk(clk), .rst_n(rst_n), .din(bus.start), .rise(w_start_re)
  );
  tdc_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_stop_edge (
    .clk(clk), .rst_n(rst_n), .din(bus.stop), .rise(w_stop_re)
  );
`else
  tdc_edge_detect u_start_edge (
    .clk(clk), .rst_n(rst_n), .din(bus.start), .rise(w_start_re)
  );
  tdc_edge_detect u_stop_edge (
    .clk(clk), .rst_n(rst_n), .din(bus.stop), .rise(w_stop_re)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // enable is checked before stop so an abort wins even on the stop cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.enable && w_start_re) begin
          w_next_state = COUNT;
        end
      end
      COUNT: begin
        if (!bus.enable) begin
          w_next_state = IDLE;
        end else if (w_stop_re || (r_count == c_CNT_LIMIT)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clear = 1'b0;
    w_cnt_inc   = 1'b0;
    w_load      = 1'b0;
    w_load_ovf  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clear = bus.enable & w_start_re;
      end
      COUNT: begin
        if (bus.enable) begin
          if (w_stop_re) begin
            w_load = 1'b1;
          end else if (r_count == c_CNT_LIMIT) begin
            w_load     = 1'b1;
            w_load_ovf = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_cnt_clear) begin
        r_count <= '0;
      end else if (w_cnt_inc) begin
        r_count <= r_count + c_ONE;
      end
      if (w_load) begin
        r_result   <= w_load_ovf ? c_OVF_VALUE : (r_count + c_ONE);
        r_overflow <= w_load_ovf;
      end
      r_valid <= (w_next_state == DONE);
      r_busy  <= (w_next_state != IDLE);
    end
  end

  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: doc/tdc_coarse_counter.md
Name: tdc_coarse_counter

Overview:
- Coarse time-to-digital stage; runs on the bench/board master clock and consumes that clock directly.
- Measures the START-to-STOP interval as an integer number of clk cycles.
- Delivers each measurement through a valid/ready handshake to the downstream readout/FIFO stage.
- Provides the coarse word for a later fine-interpolation stage.

Parameters:
- WIDTH, 16, width of the cycle counter and of result.
- SYNC_STAGES, 2, flip-flop count of each input synchronizer; used only when INPUT_SYNC_EN is defined; legal values ≥2.

Ports:
- clk  in  1  master clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; de-assertion is synchronous to clk at integration level.
- enable  in  1  arms the block; low forces return to IDLE.
- start  in  1  start event, level signal; its rising edge is the event.
- stop  in  1  stop event, level signal; its rising edge is the event.
- result  out  WIDTH  measured interval in clk cycles.
- overflow  out  1  result saturated; no stop was seen.
- valid  out  1  result/overflow are held and valid.
- ready  in  1  downstream accepts result.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, result=0, overflow=0, valid=0, busy=0, edge-detect history=0.
- Edge detection: start_re/stop_re = current sample high AND previous sample low, one flop of history each.
- Without INPUT_SYNC_EN, start and stop are treated as synchronous to clk.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - start_re while enable=1 → COUNT; counter cleared to 0.
  - stop_re ignored, including a stop_re in the same cycle as start_re.
- COUNT:
  - Counter increments by 1 each cycle.
  - Define cycle t0 = the start_re cycle and tn = the stop_re cycle, n ≥ 1.
  - At tn: result ← n (counter+1); overflow ← 0; → DONE.
  - start_re in COUNT is ignored; there is no restart.
  - If the counter reaches 2^WIDTH−2 without stop_re: next edge gives result ← 2^WIDTH−1, overflow ← 1, → DONE.
  - enable=0 in any COUNT cycle, including one with stop_re: → IDLE, no result, outputs unchanged.
- DONE:
  - valid=1; result and overflow held stable.
  - valid & ready → IDLE and valid=0 on the next edge.
  - All start/stop edges are dropped while in DONE.
  - enable has no effect in DONE; a pending result is never lost.
- Latency: valid rises on the clk edge after the stop_re cycle. Back-to-back turnaround: the earliest new start_re is accepted in the cycle after the handshake.
- result and overflow change only on entry to DONE and otherwise hold their last value.
- busy = (state ≠ IDLE), registered together with state.

Optional Feature:
- Macro INPUT_SYNC_EN.
- Defined:
  - start and stop each pass through a SYNC_STAGES-flop synchronizer before edge detection.
  - Both event paths get equal added latency, so result is unchanged; valid is delayed by SYNC_STAGES cycles relative to the raw stop edge.
  - Reset clears the synchronizer flops.
- Undefined: no synchronizer; edge detection samples the raw inputs directly.

Decomposition:
- Shared package tdc_pkg:
  - state enum {IDLE, COUNT, DONE}.
  - TDC_COARSE_WIDTH default = 16.
  - Overflow sentinel constant (all-ones).
- Sub-module tdc_edge_detect:
  - Optional synchronizer chain plus one-flop rising-edge detector.
  - Ports clk, rst_n, din, rise.
  - Instantiated twice, for start and for stop.

Test Plan (10 ns clk, WIDTH=16 unless stated):
- Reset mid-COUNT: drop rst_n asynchronously between edges → busy, valid, overflow and result go to 0 immediately; after release the next start/stop pair measures correctly.
- Basic interval: enable=1, ready=1, start rises, stop rises 37 cycles later → result=37, overflow=0, valid high exactly 1 cycle, busy low 1 cycle after the handshake.
- Minimum and coincident edges:
  - stop 1 cycle after start → result=1.
  - start and stop rising in the same cycle → measurement begins and the stop is ignored; a later stop 5 cycles after start → result=5.
- Overflow: WIDTH=8, start with no stop → after 255 cycles result=255, overflow=1, valid=1.
- Backpressure: ready=0 for 20 cycles after valid; issue extra start/stop pulses meanwhile → result stable, extra events dropped; raising ready clears valid next cycle.
- Enable abort and sync option:
  - enable dropped mid-COUNT → IDLE, valid never asserts.
  - With INPUT_SYNC_EN and asynchronous start/stop jitter → result within ±1 of the expected cycle count; valid delayed by exactly 2 cycles relative to the non-sync build.
